// File: rtl/cdb_arbiter_if.sv
// Result-producer / CDB broadcast bundle for cdb_arbiter.
// The slave modport is the arbiter; the master modport is the producer/consumer side.
interface cdb_arbiter_if #(
    parameter int NUM_SRC   = 2,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx;
    logic [NUM_SRC*DATA_W-1:0]    src_val;
    logic [NUM_SRC-1:0]           src_ready;
    logic                         cdb_en;
    logic [ROB_IDX_W-1:0]         cdb_rob_idx;
    logic [DATA_W-1:0]            cdb_val;
    logic [1:0]                   cdb_src;

    modport slave (
        input  src_valid, src_rob_idx, src_val,
        output src_ready, cdb_en, cdb_rob_idx, cdb_val, cdb_src
    );

    modport master (
        output src_valid, src_rob_idx, src_val,
        input  src_ready, cdb_en, cdb_rob_idx, cdb_val, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a 1-entry holding slot per result source.
// Optional macro CDB_BYPASS_EN lets an incoming result win and broadcast without passing through its slot.
module cdb_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         roll_back,
    cdb_arbiter_if.slave bus
);
    logic [NUM_SRC-1:0]   slot_v;
    logic [ROB_IDX_W-1:0] slot_idx [NUM_SRC];
    logic [DATA_W-1:0]    slot_val [NUM_SRC];
    logic [1:0]           rr_ptr;

    logic [NUM_SRC-1:0]   cand, grant, accept, bypass, store;
    logic                 found;
    logic [1:0]           win, ptr_next;
    logic [ROB_IDX_W-1:0] win_idx;
    logic [DATA_W-1:0]    win_val;

    logic                 cdb_en_q;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q;
    logic [DATA_W-1:0]    cdb_val_q;
    logic [1:0]           cdb_src_q;

`ifdef CDB_BYPASS_EN
    assign cand   = slot_v | (bus.src_valid & ~slot_v);
    assign bypass = grant & ~slot_v;
`else
    assign cand   = slot_v;
    assign bypass = '0;
`endif

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
    always_comb begin : arbitrate
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
        grant = found ? (NUM_SRC'(1) << win) : '0;
    end

    // A bypass winner has an empty slot, so its payload comes straight from the source bus.
    always_comb begin : winner_data
        win_idx = '0;
        win_val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                if (slot_v[i]) begin
                    win_idx = slot_idx[i];
                    win_val = slot_val[i];
                end else begin
                    win_idx = bus.src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    win_val = bus.src_val[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign ptr_next      = (win == 2'(NUM_SRC - 1)) ? 2'd0 : win + 2'd1;
    assign bus.src_ready = {NUM_SRC{rdy_in & ~roll_back}} & (~slot_v | grant);
    assign accept        = bus.src_valid & bus.src_ready;
    assign store         = accept & ~bypass;

    // NOTE: sequential state uses non-blocking '<=' only.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            slot_v        <= '0;
            rr_ptr        <= '0;
            cdb_en_q      <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_val_q     <= '0;
            cdb_src_q     <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                slot_v   <= '0;
                rr_ptr   <= '0;
                cdb_en_q <= 1'b0;
            end else begin
                slot_v   <= (slot_v & ~grant) | store;
                cdb_en_q <= found;
                if (found) begin
                    cdb_rob_idx_q <= win_idx;
                    cdb_val_q     <= win_val;
                    cdb_src_q     <= win;
                    rr_ptr        <= ptr_next;
                end
            end
        end
    end

    // NOTE: slot payload is qualified by slot_v, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (store[i]) begin
                slot_idx[i] <= bus.src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                slot_val[i] <= bus.src_val[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.cdb_en      = cdb_en_q;
    assign bus.cdb_rob_idx = cdb_rob_idx_q;
    assign bus.cdb_val     = cdb_val_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a slot-level model.
// Works with or without CDB_BYPASS_EN defined.
module tb_cdb_arbiter;
    localparam int N  = 2;
    localparam int IW = 4;
    localparam int DW = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_in, rdy_in, roll_back;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(N), .ROB_IDX_W(IW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.NUM_SRC(N), .ROB_IDX_W(IW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .roll_back (roll_back),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one holding entry per source plus the broadcast register
    bit            m_v   [N];
    logic [IW-1:0] m_idx [N];
    logic [DW-1:0] m_val [N];
    int            m_ptr;
    bit            m_en;
    logic [IW-1:0] m_cidx;
    logic [DW-1:0] m_cval;
    int            m_csrc;
    bit            m_acc [N];

    int obs_src[$];
    int obs_idx[$];
    bit stall0;

    function automatic logic [IW-1:0] in_idx(int i);
        return bus.src_rob_idx[i*IW +: IW];
    endfunction

    function automatic logic [DW-1:0] in_val(int i);
        return bus.src_val[i*DW +: DW];
    endfunction

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr + k) % N;
            if (m_v[s] || (BYP && bus.src_valid[s])) return s;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int w;
        w = m_winner();
        for (int i = 0; i < N; i++)
            r[i] = rdy_in && !roll_back && (!m_v[i] || w == i);
        return r;
    endfunction

    function automatic void m_update();
        int w;
        logic [N-1:0] r;
        bit was_v [N];
        for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
        if (rst_in) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_ptr = 0; m_en = 1'b0; m_cidx = '0; m_cval = '0; m_csrc = 0;
            return;
        end
        if (!rdy_in) return;
        if (roll_back) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_ptr = 0; m_en = 1'b0;
            return;
        end
        w = m_winner();
        r = m_ready();
        for (int i = 0; i < N; i++) was_v[i] = m_v[i];
        if (w >= 0) begin
            m_en   = 1'b1;
            m_csrc = w;
            if (was_v[w]) begin
                m_cidx = m_idx[w]; m_cval = m_val[w];
            end else begin
                m_cidx = in_idx(w); m_cval = in_val(w);
            end
            m_v[w] = 1'b0;
            m_ptr  = (w + 1) % N;
        end else begin
            m_en = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.src_valid[i] && r[i]) begin
                m_acc[i] = 1'b1;
                if (!(i == w && !was_v[i])) begin
                    m_v[i] = 1'b1; m_idx[i] = in_idx(i); m_val[i] = in_val(i);
                end
            end
        end
    endfunction

    task automatic set_src(int i, bit v, logic [IW-1:0] idx, logic [DW-1:0] val);
        bus.src_valid[i]          = v;
        bus.src_rob_idx[i*IW +: IW] = idx;
        bus.src_val[i*DW +: DW]     = val;
    endtask

    task automatic clear_src();
        bus.src_valid = '0;
    endtask

    // One clock: check src_ready mid-cycle, advance model on the edge, check cdb_* just after it
    task automatic step();
        logic [N-1:0] er;
        @(negedge clk);
        if (!rst_in) begin
            er = m_ready();
            tests++;
            if (bus.src_ready !== er) begin
                fails++;
                $display("FAIL src_ready @%0t: got %b expected %b", $time, bus.src_ready, er);
            end
            if (bus.src_valid[0] && !bus.src_ready[0]) stall0 = 1'b1;
        end
        @(posedge clk);
        m_update();
        #1;
        tests++;
        if (bus.cdb_en !== m_en || bus.cdb_rob_idx !== m_cidx || bus.cdb_val !== m_cval ||
            bus.cdb_src !== 2'(m_csrc)) begin
            fails++;
            $display("FAIL cdb_out @%0t: got en=%b idx=%0d val=%h src=%0d expected en=%b idx=%0d val=%h src=%0d",
                     $time, bus.cdb_en, bus.cdb_rob_idx, bus.cdb_val, bus.cdb_src,
                     m_en, m_cidx, m_cval, m_csrc);
        end
        if (bus.cdb_en === 1'b1) begin
            obs_src.push_back(int'(bus.cdb_src));
            obs_idx.push_back(int'(bus.cdb_rob_idx));
        end
    endtask

    task automatic do_reset(int cycles);
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
        clear_src();
        repeat (cycles) step();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        tests++;
        if (bus.cdb_en !== 1'b0 || bus.cdb_val !== '0 || bus.cdb_rob_idx !== '0 || bus.cdb_src !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b val=%h idx=%0d src=%0d expected all zero",
                     bus.cdb_en, bus.cdb_val, bus.cdb_rob_idx, bus.cdb_src);
        end
        tests++;
        if (bus.src_ready !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 11", bus.src_ready);
        end
        repeat (2) step();
    endtask

    task automatic test_single();
        int pulses, at;
        int lat;
        lat = BYP ? 0 : 1;
        pulses = 0; at = -1;
        for (int s = 0; s < 5; s++) begin
            if (s == 0) set_src(0, 1'b1, 4'd3, 32'h0000_00AA);
            else clear_src();
            step();
            if (bus.cdb_en === 1'b1) begin
                pulses++;
                if (at < 0) at = s;
                tests++;
                if (bus.cdb_rob_idx !== 4'd3 || bus.cdb_val !== 32'hAA || bus.cdb_src !== 2'd0) begin
                    fails++;
                    $display("FAIL single_data: got idx=%0d val=%h src=%0d expected idx=3 val=aa src=0",
                             bus.cdb_rob_idx, bus.cdb_val, bus.cdb_src);
                end
            end
        end
        tests++;
        if (pulses != 1 || at != lat) begin
            fails++;
            $display("FAIL single_latency: got %0d pulses at step %0d expected 1 pulse at step %0d",
                     pulses, at, lat);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1);
        obs_idx.delete(); obs_src.delete();
        set_src(0, 1'b1, 4'd5, 32'h11);
        set_src(1, 1'b1, 4'd6, 32'h22);
        step();
        clear_src();
        set_src(0, 1'b1, 4'd7, 32'h33);
        step();
        clear_src();
        repeat (4) step();
        tests++;
        if (obs_idx.size() != 3 || obs_idx[0] != 5 || obs_idx[1] != 6 || obs_idx[2] != 7) begin
            fails++;
            $display("FAIL simultaneous_order: got %0d broadcasts %p expected 5,6,7", obs_idx.size(), obs_idx);
        end
    endtask

    task automatic test_back_to_back();
        int rs, ls, cyc;
        do_reset(1);
        obs_idx.delete(); obs_src.delete();
        stall0 = 1'b0;
        rs = 0; ls = 0; cyc = 0;
        while ((rs < 4 || ls < 4) && cyc < 60) begin
            set_src(0, rs < 4, 4'(rs), 32'h100 + rs);
            set_src(1, ls < 4, 4'(8 + ls), 32'h200 + ls);
            step();
            if (m_acc[0]) rs++;
            if (m_acc[1]) ls++;
            cyc++;
        end
        clear_src();
        repeat (6) step();
        tests++;
        if (rs != 4 || ls != 4) begin
            fails++;
            $display("FAIL backpressure_timeout: accepted rs=%0d lsb=%0d expected 4 and 4", rs, ls);
        end
        tests++;
        if (obs_idx.size() != 8) begin
            fails++;
            $display("FAIL backpressure_count: got %0d pulses expected 8", obs_idx.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                tests++;
                if (obs_src[j] != j % 2 || obs_idx[j] != ((j % 2) ? 8 + j / 2 : j / 2)) begin
                    fails++;
                    $display("FAIL backpressure_seq[%0d]: got src=%0d idx=%0d expected src=%0d idx=%0d",
                             j, obs_src[j], obs_idx[j], j % 2, (j % 2) ? 8 + j / 2 : j / 2);
                end
            end
        end
        tests++;
        if (!stall0) begin
            fails++;
            $display("FAIL backpressure_stall: got no src_ready[0] stall expected at least one");
        end
    endtask

    task automatic test_rollback();
        do_reset(1);
        set_src(0, 1'b1, 4'd1, 32'h1);
        step();
        clear_src();
        step();
        set_src(0, 1'b1, 4'd2, 32'h2);
        set_src(1, 1'b1, 4'd9, 32'h9);
        step();
        set_src(0, 1'b1, 4'd12, 32'hC);
        set_src(1, 1'b1, 4'd13, 32'hD);
        roll_back = 1'b1;
        #1;
        tests++;
        if (bus.src_ready !== 2'b00) begin
            fails++;
            $display("FAIL rollback_ready: got %b expected 00", bus.src_ready);
        end
        step();
        roll_back = 1'b0;
        clear_src();
        tests++;
        if (bus.cdb_en !== 1'b0) begin
            fails++;
            $display("FAIL rollback_en: got %b expected 0", bus.cdb_en);
        end
        obs_idx.delete(); obs_src.delete();
        repeat (4) step();
        tests++;
        if (obs_idx.size() != 0) begin
            fails++;
            $display("FAIL rollback_flush: got %0d broadcasts expected 0", obs_idx.size());
        end
        set_src(0, 1'b1, 4'd10, 32'hA0);
        set_src(1, 1'b1, 4'd11, 32'hB0);
        step();
        clear_src();
        repeat (3) step();
        tests++;
        if (obs_src.size() != 2 || obs_src[0] != 0 || obs_src[1] != 1) begin
            fails++;
            $display("FAIL rollback_ptr: got %0d broadcasts srcs %p expected 0 then 1", obs_src.size(), obs_src);
        end
    endtask

    task automatic test_freeze();
        int n;
        do_reset(1);
        set_src(0, 1'b1, 4'd4, 32'h44);
        set_src(1, 1'b1, 4'd8, 32'h88);
        step();
        clear_src();
        n = 0;
        while (bus.cdb_en !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        tests++;
        if (bus.cdb_en !== 1'b1 || bus.cdb_rob_idx !== 4'd4) begin
            fails++;
            $display("FAIL freeze_setup: got en=%b idx=%0d expected en=1 idx=4", bus.cdb_en, bus.cdb_rob_idx);
        end
        rdy_in = 1'b0;
        set_src(0, 1'b1, 4'd15, 32'hF);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus.src_ready !== 2'b00) begin
                fails++;
                $display("FAIL freeze_ready[%0d]: got %b expected 00", c, bus.src_ready);
            end
            step();
            tests++;
            if (bus.cdb_en !== 1'b1 || bus.cdb_rob_idx !== 4'd4 || bus.cdb_val !== 32'h44) begin
                fails++;
                $display("FAIL freeze_hold[%0d]: got en=%b idx=%0d val=%h expected en=1 idx=4 val=44",
                         c, bus.cdb_en, bus.cdb_rob_idx, bus.cdb_val);
            end
        end
        rdy_in = 1'b1;
        clear_src();
        step();
        tests++;
        if (bus.cdb_en !== 1'b1 || bus.cdb_rob_idx !== 4'd8 || bus.cdb_src !== 2'd1) begin
            fails++;
            $display("FAIL freeze_resume: got en=%b idx=%0d src=%0d expected en=1 idx=8 src=1",
                     bus.cdb_en, bus.cdb_rob_idx, bus.cdb_src);
        end
        repeat (2) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rdy_in    = ($urandom % 8) != 0;
            roll_back = ($urandom % 32) == 0;
            for (int i = 0; i < N; i++)
                set_src(i, ($urandom % 3) != 0, 4'($urandom), $urandom);
            step();
        end
        rdy_in = 1'b1; roll_back = 1'b0;
        clear_src();
        repeat (6) step();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
        bus.src_valid = '0; bus.src_rob_idx = '0; bus.src_val = '0;
        stall0 = 1'b0;
        m_ptr = 0; m_en = 1'b0; m_cidx = '0; m_cval = '0; m_csrc = 0;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0; m_idx[i] = '0; m_val[i] = '0; m_acc[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_rollback();
        test_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
